// File: rtl/mem_arbiter_if.sv
// CPU-side and RAM-side bus bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the environment (CPU + RAM) view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imemRen;
  logic [ADDR_W-1:0] imemaddr;
  logic              dmmRen;
  logic              dmmWen;
  logic [ADDR_W-1:0] dmmaddr;
  logic [DATA_W-1:0] dmmstore;
  logic              i_ready;
  logic              d_ready;
  logic [DATA_W-1:0] imemload;
  logic [DATA_W-1:0] dmmload;
  logic              err;
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;

  modport slave (
    input  imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, ram_rdata, ram_ready,
    output i_ready, d_ready, imemload, dmmload, err, ram_ren, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, ram_rdata, ram_ready,
    input  i_ready, d_ready, imemload, dmmload, err, ram_ren, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and data loads/stores onto one RAM port with a timeout abort.
// Optional round-robin arbitration is enabled by defining MEM_ARB_FAIR_EN.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] ABORT_WORD = {DATA_W/16{16'hBAD1}};

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic              ren;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] iload;
  logic [DATA_W-1:0] dload;
  logic              irdy;
  logic              drdy;
  logic              err_q;
  logic              d_req;
  logic              grant_d;

  assign d_req = bus.dmmRen | bus.dmmWen;

`ifdef MEM_ARB_FAIR_EN
  // last_grant: 1 = data side served last, 0 = instruction side
  logic last_grant;
  assign grant_d = d_req & (~bus.imemRen | ~last_grant);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      ren   <= 1'b0;
      wen   <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      iload <= '0;
      dload <= '0;
      irdy  <= 1'b0;
      drdy  <= 1'b0;
      err_q <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      irdy  <= 1'b0;
      drdy  <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (grant_d) begin
            // A simultaneous read+write request is treated as a store
            addr  <= bus.dmmaddr;
            wdata <= bus.dmmstore;
            wen   <= bus.dmmWen;
            ren   <= ~bus.dmmWen;
            state <= BUSY_D;
`ifdef MEM_ARB_FAIR_EN
            last_grant <= 1'b1;
`endif
          end else if (bus.imemRen) begin
            addr  <= bus.imemaddr;
            ren   <= 1'b1;
            wen   <= 1'b0;
            state <= BUSY_I;
`ifdef MEM_ARB_FAIR_EN
            last_grant <= 1'b0;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.ram_ready || count == LAST_CNT) begin
            ren   <= 1'b0;
            wen   <= 1'b0;
            irdy  <= (state == BUSY_I);
            drdy  <= (state == BUSY_D);
            err_q <= ~bus.ram_ready;
            state <= RESP;
            if (state == BUSY_I)
              iload <= bus.ram_ready ? bus.ram_rdata : ABORT_WORD;
            else if (!wen)
              dload <= bus.ram_ready ? bus.ram_rdata : ABORT_WORD;
          end else begin
            count <= count + 1'b1;
          end
        end
        RESP: begin
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_ren   = ren;
  assign bus.ram_wen   = wen;
  assign bus.ram_addr  = addr;
  assign bus.ram_wdata = wdata;
  assign bus.imemload  = iload;
  assign bus.dmmload   = dload;
  assign bus.i_ready   = irdy;
  assign bus.d_ready   = drdy;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, fetch, store, contention, timeout,
// back-to-back fetches and reset in the middle of an access.
module tb_mem_arbiter;
  localparam int TIMEOUT = 5;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic iren, input logic [31:0] iaddr,
                               input logic dren, input logic dwen, input logic [31:0] daddr,
                               input logic [31:0] dstore, input logic rrdy, input logic [31:0] rdata);
    bus.imemRen   = iren;
    bus.imemaddr  = iaddr;
    bus.dmmRen    = dren;
    bus.dmmWen    = dwen;
    bus.dmmaddr   = daddr;
    bus.dmmstore  = dstore;
    bus.ram_ready = rrdy;
    bus.ram_rdata = rdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each cycle is observed and driven 1 time unit after its rising edge
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) nextCycle();
    checkOutput("rst_ren", {31'b0, bus.ram_ren}, 0);
    checkOutput("rst_wen", {31'b0, bus.ram_wen}, 0);
    checkOutput("rst_iready", {31'b0, bus.i_ready}, 0);
    checkOutput("rst_dready", {31'b0, bus.d_ready}, 0);
    checkOutput("rst_err", {31'b0, bus.err}, 0);
    checkOutput("rst_imemload", bus.imemload, 0);
    rst_n = 1'b1;
    nextCycle();

    $display("[TB] store");
    applyStimulus(0, 0, 0, 1, 32'h00010001, 32'hABCDABCD, 0, 0);
    nextCycle();
    checkOutput("st_wen", {31'b0, bus.ram_wen}, 1);
    checkOutput("st_ren", {31'b0, bus.ram_ren}, 0);
    checkOutput("st_addr", bus.ram_addr, 32'h00010001);
    checkOutput("st_wdata", bus.ram_wdata, 32'hABCDABCD);
    applyStimulus(0, 0, 0, 1, 32'h00010001, 32'hABCDABCD, 1, 32'h99999999);
    nextCycle();
    checkOutput("st_dready", {31'b0, bus.d_ready}, 1);
    checkOutput("st_wen_off", {31'b0, bus.ram_wen}, 0);
    checkOutput("st_dmmload", bus.dmmload, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("st_dready_end", {31'b0, bus.d_ready}, 0);

    $display("[TB] fetch");
    applyStimulus(1, 32'h12341234, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      nextCycle();
      checkOutput("fe_ren", {31'b0, bus.ram_ren}, 1);
      checkOutput("fe_addr", bus.ram_addr, 32'h12341234);
      checkOutput("fe_iready_wait", {31'b0, bus.i_ready}, 0);
      if (c == 3) applyStimulus(1, 32'h12341234, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    end
    nextCycle();
    checkOutput("fe_iready", {31'b0, bus.i_ready}, 1);
    checkOutput("fe_dready", {31'b0, bus.d_ready}, 0);
    checkOutput("fe_imemload", bus.imemload, 32'hDEADBEEF);
    checkOutput("fe_ren_off", {31'b0, bus.ram_ren}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("fe_iready_end", {31'b0, bus.i_ready}, 0);

    $display("[TB] contention after a fetch");
    applyStimulus(1, 32'h100, 1, 0, 32'h200, 0, 0, 0);
    nextCycle();
    checkOutput("ct_addr_d", bus.ram_addr, 32'h200);
    checkOutput("ct_ren_d", {31'b0, bus.ram_ren}, 1);
    applyStimulus(1, 32'h100, 1, 0, 32'h200, 0, 1, 32'h5555AAAA);
    nextCycle();
    checkOutput("ct_dready", {31'b0, bus.d_ready}, 1);
    checkOutput("ct_iready0", {31'b0, bus.i_ready}, 0);
    checkOutput("ct_dmmload", bus.dmmload, 32'h5555AAAA);
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("ct_idle_d", {31'b0, bus.d_ready}, 0);
    checkOutput("ct_idle_i", {31'b0, bus.i_ready}, 0);
    nextCycle();
    checkOutput("ct_addr_i", bus.ram_addr, 32'h100);
    checkOutput("ct_ren_i", {31'b0, bus.ram_ren}, 1);
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 1, 32'h11112222);
    nextCycle();
    checkOutput("ct_iready", {31'b0, bus.i_ready}, 1);
    checkOutput("ct_imemload", bus.imemload, 32'h11112222);
    checkOutput("ct_dmmload_kept", bus.dmmload, 32'h5555AAAA);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();

    $display("[TB] timeout");
    applyStimulus(0, 0, 1, 0, 32'h300, 0, 0, 0);
    nextCycle();
    for (int c = 1; c <= TIMEOUT; c++) begin
      checkOutput("to_ren", {31'b0, bus.ram_ren}, 1);
      checkOutput("to_dready_wait", {31'b0, bus.d_ready}, 0);
      nextCycle();
    end
    checkOutput("to_dready", {31'b0, bus.d_ready}, 1);
    checkOutput("to_err", {31'b0, bus.err}, 1);
    checkOutput("to_dmmload", bus.dmmload, 32'hBAD1BAD1);
    checkOutput("to_ren_off", {31'b0, bus.ram_ren}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("to_err_end", {31'b0, bus.err}, 0);

    // Last grant was data, so the fair build serves the instruction side first here
    $display("[TB] contention after a data access");
    applyStimulus(1, 32'h600, 1, 0, 32'h700, 0, 0, 0);
    nextCycle();
    checkOutput("c2_addr", bus.ram_addr, FAIR ? 32'h600 : 32'h700);
    applyStimulus(1, 32'h600, 1, 0, 32'h700, 0, 1, 32'h77776666);
    nextCycle();
    checkOutput("c2_iready", {31'b0, bus.i_ready}, {31'b0, FAIR});
    checkOutput("c2_dready", {31'b0, bus.d_ready}, {31'b0, ~FAIR});
    checkOutput("c2_err", {31'b0, bus.err}, 0);
    checkOutput("c2_load", FAIR ? bus.imemload : bus.dmmload, 32'h77776666);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("c2_idle_ren", {31'b0, bus.ram_ren}, 0);

    $display("[TB] back-to-back fetches");
    applyStimulus(1, 32'h0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("bb_addr0", bus.ram_addr, 32'h0);
    applyStimulus(1, 32'h0, 0, 0, 0, 0, 1, 32'hA0A0A0A0);
    nextCycle();
    checkOutput("bb_iready0", {31'b0, bus.i_ready}, 1);
    checkOutput("bb_load0", bus.imemload, 32'hA0A0A0A0);
    applyStimulus(1, 32'h4, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("bb_gap_i", {31'b0, bus.i_ready}, 0);
    checkOutput("bb_gap_ren", {31'b0, bus.ram_ren}, 0);
    nextCycle();
    checkOutput("bb_addr4", bus.ram_addr, 32'h4);
    checkOutput("bb_iready_mid", {31'b0, bus.i_ready}, 0);
    applyStimulus(1, 32'h4, 0, 0, 0, 0, 1, 32'hB4B4B4B4);
    nextCycle();
    checkOutput("bb_iready1", {31'b0, bus.i_ready}, 1);
    checkOutput("bb_load1", bus.imemload, 32'hB4B4B4B4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();

    $display("[TB] reset during a data access");
    applyStimulus(0, 0, 1, 0, 32'h500, 0, 0, 0);
    nextCycle();
    checkOutput("rm_ren_before", {31'b0, bus.ram_ren}, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rm_ren", {31'b0, bus.ram_ren}, 0);
    checkOutput("rm_addr", bus.ram_addr, 0);
    checkOutput("rm_dmmload", bus.dmmload, 0);
    checkOutput("rm_imemload", bus.imemload, 0);
    checkOutput("rm_dready", {31'b0, bus.d_ready}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) nextCycle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      checkOutput("rm_post_dready", {31'b0, bus.d_ready}, 0);
      checkOutput("rm_post_ren", {31'b0, bus.ram_ren}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
